// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with write bypass and a pending-bit scoreboard
module regfile_sb #(
   parameter int XLEN    = 32,
   parameter int NREG    = 32,
   parameter int NRD     = 2,
   parameter int NWR     = 2,
   parameter int ZERO_X0 = 1,
   localparam int AW     = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_valid,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_rd,
   output logic                iss_rdy,
   input  logic                flush,
   output logic [AW:0]         pend_cnt
);

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic [NREG-1:0] pend_q, pend_d, wmask;
   logic [AW:0]     pend_cnt_q, pend_cnt_d;
   logic            iss_set;

   // merge this cycle's writes into next-state storage; later ports override earlier ones
   always_comb begin
      wmask = '0;
      for (int r = 0; r < NREG; r++) regs_d[r] = regs_q[r];
      for (int p = 0; p < NWR; p++)
         if (wr_en[p] && !(ZERO_X0 != 0 && wr_addr[p*AW +: AW] == '0)) begin
            regs_d[wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
            wmask[wr_addr[p*AW +: AW]]  = 1'b1;
         end
   end

   // reads see next-state storage, which already carries the bypassed write data
   always_comb begin
      rd_data  = '0;
      rd_valid = '0;
      for (int k = 0; k < NRD; k++) begin
         rd_data[k*XLEN +: XLEN] = regs_d[rd_addr[k*AW +: AW]];
         rd_valid[k] = !pend_q[rd_addr[k*AW +: AW]] || wmask[rd_addr[k*AW +: AW]];
      end
   end

   // scoreboard next state: issue beats write-clear, flush beats everything
   always_comb begin
      iss_rdy    = !pend_q[iss_rd] || wmask[iss_rd] || (ZERO_X0 != 0 && iss_rd == '0);
      iss_set    = iss_en && iss_rdy && !(ZERO_X0 != 0 && iss_rd == '0);
      pend_d     = pend_q & ~wmask;
      if (iss_set) pend_d[iss_rd] = 1'b1;
      if (flush) pend_d = '0;
      pend_cnt_d = '0;
      for (int r = 0; r < NREG; r++) pend_cnt_d = pend_cnt_d + {{AW{1'b0}}, pend_d[r]};
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
         pend_q     <= '0;
         pend_cnt_q <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) regs_q[r] <= regs_d[r];
         pend_q     <= pend_d;
         pend_cnt_q <= pend_cnt_d;
      end
   end

   assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed self-checking bench for regfile_sb
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_valid;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic        iss_en;
   logic [4:0]  iss_rd;
   logic        iss_rdy;
   logic        flush;
   logic [5:0]  pend_cnt;
   int          n_chk = 0;
   int          n_fail = 0;

   regfile_sb dut (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
      .iss_rd(iss_rd), .iss_rdy(iss_rdy), .flush(flush), .pend_cnt(pend_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 0; wr_en = 0; wr_addr = 0; wr_data = 0; iss_en = 0; flush = 0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1; wr_en = 2'b01; wr_addr = 10'd5; wr_data = 64'h1; iss_en = 1; iss_rd = 5;
      tick();
      idle(); rd_addr = {5'd5, 5'd5}; iss_rd = 5;
      #1;
      n_chk++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
      n_chk++; if (rd_valid !== 2'b11) begin n_fail++; $display("FAIL reset_rd_valid got=%b exp=11", rd_valid); end
      n_chk++; if (iss_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_iss_rdy got=%b exp=1", iss_rdy); end
      n_chk++; if (pend_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_pend_cnt got=%0d exp=0", pend_cnt); end
   endtask

   task automatic test_bypass();
      idle(); wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF}; rd_addr = {5'd0, 5'd5};
      #1;
      n_chk++; if (rd_data[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_same_cycle got=%h exp=deadbeef", rd_data[31:0]); end
      tick();
      idle();
      #1;
      n_chk++; if (rd_data[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_stored got=%h exp=deadbeef", rd_data[31:0]); end
   endtask

   task automatic test_same_addr();
      idle(); wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h2222, 32'h1111}; rd_addr = {5'd7, 5'd5};
      #1;
      n_chk++; if (rd_data[63:32] !== 32'h2222) begin n_fail++; $display("FAIL dual_write_bypass got=%h exp=2222", rd_data[63:32]); end
      tick();
      idle();
      #1;
      n_chk++; if (rd_data[63:32] !== 32'h2222) begin n_fail++; $display("FAIL dual_write_stored got=%h exp=2222", rd_data[63:32]); end
      n_chk++; if (rd_data[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL other_reg_kept got=%h exp=deadbeef", rd_data[31:0]); end
   endtask

   task automatic test_x0();
      idle(); wr_en = 2'b10; wr_addr = {5'd0, 5'd0}; wr_data = {32'hFFFFFFFF, 32'h0};
      iss_en = 1; iss_rd = 0; rd_addr = {5'd0, 5'd0};
      #1;
      n_chk++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL x0_bypass got=%h exp=0", rd_data); end
      n_chk++; if (iss_rdy !== 1'b1) begin n_fail++; $display("FAIL x0_iss_rdy got=%b exp=1", iss_rdy); end
      tick();
      idle();
      #1;
      n_chk++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL x0_stored got=%h exp=0", rd_data); end
      n_chk++; if (pend_cnt !== 6'd0) begin n_fail++; $display("FAIL x0_pend_cnt got=%0d exp=0", pend_cnt); end
      n_chk++; if (rd_valid !== 2'b11) begin n_fail++; $display("FAIL x0_rd_valid got=%b exp=11", rd_valid); end
   endtask

   task automatic test_pending();
      idle(); iss_en = 1; iss_rd = 3; rd_addr = {5'd5, 5'd3};
      #1;
      n_chk++; if (iss_rdy !== 1'b1) begin n_fail++; $display("FAIL pend_pre_rdy got=%b exp=1", iss_rdy); end
      tick();
      idle();
      #1;
      n_chk++; if (rd_valid !== 2'b10) begin n_fail++; $display("FAIL pend_rd_valid got=%b exp=10", rd_valid); end
      n_chk++; if (iss_rdy !== 1'b0) begin n_fail++; $display("FAIL pend_iss_rdy got=%b exp=0", iss_rdy); end
      n_chk++; if (pend_cnt !== 6'd1) begin n_fail++; $display("FAIL pend_cnt_one got=%0d exp=1", pend_cnt); end
      iss_en = 1;
      tick();
      idle();
      #1;
      n_chk++; if (pend_cnt !== 6'd1) begin n_fail++; $display("FAIL waw_stall_cnt got=%0d exp=1", pend_cnt); end
      wr_en = 2'b10; wr_addr = {5'd3, 5'd0}; wr_data = {32'h42, 32'h0};
      #1;
      n_chk++; if (rd_valid[0] !== 1'b1) begin n_fail++; $display("FAIL wb_valid_comb got=%b exp=1", rd_valid[0]); end
      n_chk++; if (rd_data[31:0] !== 32'h42) begin n_fail++; $display("FAIL wb_data_comb got=%h exp=42", rd_data[31:0]); end
      n_chk++; if (iss_rdy !== 1'b1) begin n_fail++; $display("FAIL wb_iss_rdy got=%b exp=1", iss_rdy); end
      tick();
      idle();
      #1;
      n_chk++; if (pend_cnt !== 6'd0) begin n_fail++; $display("FAIL wb_pend_cnt got=%0d exp=0", pend_cnt); end
      n_chk++; if (rd_valid[0] !== 1'b1) begin n_fail++; $display("FAIL wb_valid_reg got=%b exp=1", rd_valid[0]); end
   endtask

   task automatic test_issue_write();
      idle(); iss_en = 1; iss_rd = 4; wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'hABCD};
      rd_addr = {5'd5, 5'd4};
      tick();
      idle();
      #1;
      n_chk++; if (rd_data[31:0] !== 32'hABCD) begin n_fail++; $display("FAIL iw_data got=%h exp=abcd", rd_data[31:0]); end
      n_chk++; if (rd_valid[0] !== 1'b0) begin n_fail++; $display("FAIL iw_pending got=%b exp=0", rd_valid[0]); end
      n_chk++; if (pend_cnt !== 6'd1) begin n_fail++; $display("FAIL iw_pend_cnt got=%0d exp=1", pend_cnt); end
   endtask

   task automatic test_flush_reset();
      idle(); iss_en = 1; iss_rd = 1; tick();
      iss_rd = 2; tick();
      iss_rd = 6; tick();
      idle();
      #1;
      n_chk++; if (pend_cnt !== 6'd4) begin n_fail++; $display("FAIL multi_pend_cnt got=%0d exp=4", pend_cnt); end
      flush = 1; iss_en = 1; iss_rd = 9; wr_en = 2'b01; wr_addr = {5'd0, 5'd10}; wr_data = {32'h0, 32'h55};
      tick();
      idle(); rd_addr = {5'd9, 5'd10};
      #1;
      n_chk++; if (pend_cnt !== 6'd0) begin n_fail++; $display("FAIL flush_pend_cnt got=%0d exp=0", pend_cnt); end
      n_chk++; if (rd_valid !== 2'b11) begin n_fail++; $display("FAIL flush_rd_valid got=%b exp=11", rd_valid); end
      n_chk++; if (rd_data[31:0] !== 32'h55) begin n_fail++; $display("FAIL flush_write_kept got=%h exp=55", rd_data[31:0]); end
      iss_en = 1; iss_rd = 6; tick();
      idle(); rst = 1; tick();
      rst = 0; rd_addr = {5'd7, 5'd5}; iss_rd = 6;
      #1;
      n_chk++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL rst_reads_a got=%h exp=0", rd_data); end
      n_chk++; if (pend_cnt !== 6'd0) begin n_fail++; $display("FAIL rst_pend_cnt got=%0d exp=0", pend_cnt); end
      n_chk++; if (iss_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_iss_rdy got=%b exp=1", iss_rdy); end
      rd_addr = {5'd10, 5'd4};
      #1;
      n_chk++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL rst_reads_b got=%h exp=0", rd_data); end
   endtask

   initial begin
      idle(); rd_addr = 0; iss_rd = 0;
      test_reset();
      test_bypass();
      test_same_addr();
      test_x0();
      test_pending();
      test_issue_write();
      test_flush_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
